clock_display: RTL and testbench

- Downstream stage of the hour/min/sec time-of-day counter; drives the six on-board 7-segment displays (HH:MM:SS).
- Detects any change on the time inputs and snapshots all three fields.
- Converts each field to BCD with a sequential subtract-by-10 FSM.
- Updates all six digit outputs in a single cycle, so no torn digits are displayed.

---
 rtl/clock_display_pkg.sv | 28 ++
 rtl/clock_display_seg7_decode.sv | 29 ++
 rtl/clock_display.sv | 201 ++++++++++++++++++++
 tb/tb_clock_display.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and constants for the HH:MM:SS seven-segment display driver.
package clock_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_e;
  typedef enum logic [1:0] {HOUR, MIN, SEC} field_e;

  // Active-low gfedcba segment codes
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Stored-digit value that the decoder renders as a dash
  localparam logic [3:0] DIG_DASH = 4'hF;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

endpackage

// File: rtl/clock_display_seg7_decode.sv
// BCD digit to active-low seven-segment code; 4'hF renders a dash, other
// non-decimal codes render blank.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Digit lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      DIG_DASH: seg_o = SEG_DASH;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display.sv
// Time-of-day display driver: snapshots hour/min/sec on change, converts each
// field to BCD by repeated subtraction, then loads all six digits at once.
// Optional blink-while-paused behaviour is compiled in with CLOCK_DISPLAY_BLINK_EN.
//
// state  | meaning
// IDLE   | waiting for the inputs to differ from the snapshot
// CONV   | subtract-by-10 on the current field, store digits when < 10
// UPDATE | load all six hex outputs, pulse range_err, drop busy
module clock_display
  import clock_display_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic [6:0] hex5_o,
  output logic [6:0] hex4_o,
  output logic [6:0] hex3_o,
  output logic [6:0] hex2_o,
  output logic [6:0] hex1_o,
  output logic [6:0] hex0_o,
  output logic       busy_o,
  output logic       range_err_o
);

  state_e            state_q, state_d;
  field_e            field_q, field_d;
  logic [16:0]       snap_q, snap_d;
  logic [5:0]        work_q, work_d;
  logic [2:0]        tens_q, tens_d;
  logic [5:0][3:0]   dig_q, dig_d;
  logic [2:0]        err_q, err_d;
  logic [5:0][6:0]   hex_q, hex_d;
  logic              busy_q, busy_d;
  logic              rerr_q, rerr_d;

  logic [16:0]       time_w;
  logic [5:0][6:0]   seg_w;
  logic [5:0][6:0]   disp_w;
  logic              over_w;
  logic [3:0]        tdig_w, udig_w;

  assign time_w = {hour_i, min_i, sec_i};

  // Next-state and datapath for the snapshot / convert / update sequence
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    snap_d  = snap_q;
    work_d  = work_q;
    tens_d  = tens_q;
    dig_d   = dig_q;
    err_d   = err_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    rerr_d  = 1'b0;
    over_w  = 1'b0;
    tdig_w  = {1'b0, tens_q};
    udig_w  = work_q[3:0];

    case (field_q)
      HOUR:    over_w = {1'b0, snap_q[16:12]} > HOUR_MAX;
      MIN:     over_w = snap_q[11:6] > MIN_MAX;
      default: over_w = snap_q[5:0] > SEC_MAX;
    endcase
    if (over_w) begin
      tdig_w = DIG_DASH;
      udig_w = DIG_DASH;
    end

    case (state_q)
      IDLE: begin
        if (time_w != snap_q) begin
          snap_d  = time_w;
          work_d  = {1'b0, hour_i};
          tens_d  = 3'd0;
          field_d = HOUR;
          err_d   = 3'b000;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (work_q >= 6'd10) begin
          work_d = work_q - 6'd10;
          tens_d = tens_q + 3'd1;
        end else begin
          tens_d = 3'd0;
          case (field_q)
            HOUR: begin
              dig_d[5] = tdig_w;
              dig_d[4] = udig_w;
              err_d[2] = over_w;
              work_d   = snap_q[11:6];
              field_d  = MIN;
            end
            MIN: begin
              dig_d[3] = tdig_w;
              dig_d[2] = udig_w;
              err_d[1] = over_w;
              work_d   = snap_q[5:0];
              field_d  = SEC;
            end
            default: begin
              dig_d[1] = tdig_w;
              dig_d[0] = udig_w;
              err_d[0] = over_w;
              state_d  = UPDATE;
            end
          endcase
        end
      end
      UPDATE: begin
        hex_d   = seg_w;
        rerr_d  = |err_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset blanks the display and forces a reconversion
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      field_q <= HOUR;
      snap_q  <= '1;
      work_q  <= '0;
      tens_q  <= '0;
      dig_q   <= '0;
      err_q   <= '0;
      hex_q   <= {6{SEG_BLANK}};
      busy_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      snap_q  <= snap_d;
      work_q  <= work_d;
      tens_q  <= tens_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_dec
    seg7_decode u_dec (
      .digit_i (dig_q[i]),
      .seg_o   (seg_w[i])
    );
  end

`ifdef CLOCK_DISPLAY_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt_q;
  logic          phase_q;
  logic          blank_q;

  // Blink phase timer, parked at zero while the time counter is running
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || enable_i) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      blank_q <= phase_q;
    end
  end

  assign disp_w = blank_q ? {6{SEG_BLANK}} : hex_q;
`else
  logic unused_blink;
  assign unused_blink = enable_i ^ (BLINK_DIV == 0);
  assign disp_w       = hex_q;
`endif

  assign hex5_o      = disp_w[5];
  assign hex4_o      = disp_w[4];
  assign hex3_o      = disp_w[3];
  assign hex2_o      = disp_w[2];
  assign hex1_o      = disp_w[1];
  assign hex0_o      = disp_w[0];
  assign busy_o      = busy_q;
  assign range_err_o = rerr_q;

endmodule

// File: tb/tb_clock_display.sv
// Scoreboard bench for clock_display: stimulus pushes the expected display
// for every value the DUT will capture; the monitor pops on each busy fall.
module tb_clock_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       busy, range_err;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [41:0] hex;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t q[$];
  int   lh, lm, ls;

  clock_display dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .hour_i      (hour),
    .min_i       (min),
    .sec_i       (sec),
    .hex5_o      (hex5),
    .hex4_o      (hex4),
    .hex3_o      (hex3),
    .hex2_o      (hex2),
    .hex1_o      (hex1),
    .hex0_o      (hex0),
    .busy_o      (busy),
    .range_err_o (range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int h, input int m, input int s);
    exp_t e;
    int   v[3];
    int   mx[3];
    logic [6:0] t, u;
    v[0] = h; v[1] = m; v[2] = s;
    mx[0] = 23; mx[1] = 59; mx[2] = 59;
    e.err = 1'b0;
    e.hex = '0;
    e.lat = 8'((h / 10 + 1) + (m / 10 + 1) + (s / 10 + 1) + 1);
    for (int i = 0; i < 3; i++) begin
      if (v[i] > mx[i]) begin
        t = 7'b0111111;
        u = 7'b0111111;
        e.err = 1'b1;
      end else begin
        t = seg_of(v[i] / 10);
        u = seg_of(v[i] % 10);
      end
      e.hex = {e.hex[27:0], t, u};
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply(input int h, input int m, input int s, input bit push);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    lh = h; lm = m; ls = s;
    if (push) q.push_back(model(h, m, s));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d updates still pending after %0d cycles", q.size(), n);
      q.delete();
    end
    tick(2);
  endtask

  // Monitor: every busy fall is one display update
  initial begin : monitor
    logic prev;
    int   cnt;
    exp_t e;
    prev = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (busy) cnt++;
        if (prev && !busy) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: display %0h with nothing expected", {hex5, hex4, hex3, hex2, hex1, hex0});
          end else begin
            e = q.pop_front();
            check("display", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
            check("range_err", 64'(range_err), 64'(e.err));
            check("latency", 64'(cnt), 64'(e.lat));
          end
          cnt = 0;
        end else if (range_err) begin
          total++;
          bad++;
          $display("FAIL stray_range_err: got 1 want 0 at %0t", $time);
        end
        prev = busy;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h, m, s;
    tick(3);
    check("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_range_err", 64'(range_err), 64'd0);

    apply(0, 0, 0, 1'b1);
    rst_n = 1'b1;
    tick(1);
    check("first_cycle_blank", 64'(hex5), 64'h7F);
    check("first_cycle_busy", 64'(busy), 64'd1);
    drain();

    apply(23, 59, 59, 1'b1);
    drain();

    apply(12, 34, 58, 1'b1);
    tick(2);
    apply(12, 34, 59, 1'b1);
    drain();

    apply(24, 60, 7, 1'b1);
    drain();

    apply(31, 63, 63, 1'b1);
    drain();

    apply(5, 6, 7, 1'b0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midconv_reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h7F}}));
    check("midconv_reset_busy", 64'(busy), 64'd0);
    q.push_back(model(5, 6, 7));
    rst_n = 1'b1;
    drain();

    apply(5, 6, 7, 1'b0);
    tick(5);
    check("no_retrigger_busy", 64'(busy), 64'd0);

    for (int it = 0; it < 25; it++) begin
      do begin
        h = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 23)) : int'($urandom_range(0, 31));
        m = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 59)) : int'($urandom_range(0, 63));
        s = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 59)) : int'($urandom_range(0, 63));
      end while (h == lh && m == lm && s == ls);
      apply(h, m, s, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        tick(int'($urandom_range(1, 3)));
        s = (ls + 1) % 64;
        apply(lh, lm, s, 1'b1);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
